// File: rtl/gpio_response_seq.sv
// Table-driven GPIO responder: waits for the processor's GPO to match each table
// entry in turn and answers on GPI with that entry's response after its delay.
module gpio_response_seq #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int DLY_W = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int EW = AW + 1
) (
    input  logic             XCLK,
    input  logic             XRESET_N,
    input  logic [WIDTH-1:0] XGPO,
    output logic [WIDTH-1:0] XGPI,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [WIDTH-1:0] cfg_match,
    input  logic [WIDTH-1:0] cfg_resp,
    input  logic             cfg_ne,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [EW-1:0]    num_steps,
    input  logic [DLY_W-1:0] timeout_lim,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [AW-1:0]    step
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DELAY,
        S_DONE,
        S_TMO
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] xgpi_q, xgpi_d;
    logic [DLY_W-1:0] dcnt_q, dcnt_d;
    logic [DLY_W-1:0] tcnt_q, tcnt_d;
    logic [EW-1:0]    eff_q, eff_d;
    logic [WIDTH-1:0] gpo_q;

    logic [WIDTH-1:0] mask_t  [DEPTH];
    logic [WIDTH-1:0] match_t [DEPTH];
    logic [WIDTH-1:0] resp_t  [DEPTH];
    logic             ne_t    [DEPTH];
    logic [DLY_W-1:0] delay_t [DEPTH];

    logic [WIDTH-1:0] sel_mask, sel_match, sel_resp;
    logic             sel_ne;
    logic [DLY_W-1:0] sel_delay;
    logic             hit, last, load, tmo_hit;

    function automatic logic entry_hit(input logic [WIDTH-1:0] g,
                                       input logic [WIDTH-1:0] m,
                                       input logic [WIDTH-1:0] mt,
                                       input logic             ne);
        return ((g & m) == (mt & m)) ^ ne;
    endfunction

    function automatic logic [DLY_W-1:0] sat_inc(input logic [DLY_W-1:0] v);
        return (v == '1) ? v : v + DLY_W'(1);
    endfunction

    // Stage 0: input sampling; every match decision sees only the registered GPO.
    always_ff @(posedge XCLK or negedge XRESET_N) begin
        if (!XRESET_N) begin
            gpo_q <= '0;
        end else begin
            gpo_q <= XGPO;
        end
    end

    assign busy    = (state_q == S_WAIT) || (state_q == S_DELAY);
    assign done    = (state_q == S_DONE);
    assign timeout = (state_q == S_TMO);
    assign step    = step_q;
    assign XGPI    = xgpi_q;

    // Response table; frozen while a sequence is running so the active entry stays stable.
    always_ff @(posedge XCLK or negedge XRESET_N) begin
        if (!XRESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mask_t[i]  <= '0;
                match_t[i] <= '0;
                resp_t[i]  <= '0;
                ne_t[i]    <= 1'b0;
                delay_t[i] <= '0;
            end
        end else if (cfg_we && !busy) begin
            mask_t[cfg_addr]  <= cfg_mask;
            match_t[cfg_addr] <= cfg_match;
            resp_t[cfg_addr]  <= cfg_resp;
            ne_t[cfg_addr]    <= cfg_ne;
            delay_t[cfg_addr] <= cfg_delay;
        end
    end

    always_comb begin
        sel_mask  = mask_t[step_q];
        sel_match = match_t[step_q];
        sel_resp  = resp_t[step_q];
        sel_ne    = ne_t[step_q];
        sel_delay = delay_t[step_q];
        hit       = entry_hit(gpo_q, sel_mask, sel_match, sel_ne);
        last      = ({1'b0, step_q} + EW'(1)) == eff_q;
        tmo_hit   = (timeout_lim != '0) && (tcnt_q >= timeout_lim - DLY_W'(1));
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        xgpi_d  = xgpi_q;
        dcnt_d  = dcnt_q;
        tcnt_d  = tcnt_q;
        eff_d   = eff_q;
        load    = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            step_d  = '0;
            xgpi_d  = '0;
            dcnt_d  = '0;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_TMO: begin
                    if (start) begin
                        step_d  = '0;
                        xgpi_d  = '0;
                        dcnt_d  = '0;
                        tcnt_d  = '0;
                        eff_d   = (num_steps > EW'(DEPTH)) ? EW'(DEPTH) : num_steps;
                        state_d = (num_steps == '0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A match on the same edge as the timeout limit takes priority.
                    if (hit) begin
                        if (sel_delay == '0) begin
                            load = 1'b1;
                        end else begin
                            dcnt_d  = sel_delay - DLY_W'(1);
                            state_d = S_DELAY;
                        end
                    end else if (tmo_hit) begin
                        state_d = S_TMO;
                    end else begin
                        tcnt_d = sat_inc(tcnt_q);
                    end
                end
                S_DELAY: begin
                    if (dcnt_q == '0) begin
                        load = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q - DLY_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (load) begin
                xgpi_d = sel_resp;
                tcnt_d = '0;
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + AW'(1);
                    state_d = S_WAIT;
                end
            end
        end
    end

    // Stage 1: sequencer state and the registered GPI response.
    always_ff @(posedge XCLK or negedge XRESET_N) begin
        if (!XRESET_N) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            xgpi_q  <= '0;
            dcnt_q  <= '0;
            tcnt_q  <= '0;
            eff_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            xgpi_q  <= xgpi_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
            eff_q   <= eff_d;
        end
    end

endmodule

// File: tb/tb_gpio_response_seq.sv
// Directed bench for gpio_response_seq: expected GPI responses queue up as GPO
// stimulus is driven and are checked when the response is due.
module tb_gpio_response_seq;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DLY_W = 16;

    logic             XCLK = 1'b0;
    logic             XRESET_N = 1'b0;
    logic [WIDTH-1:0] XGPO = '0;
    logic [WIDTH-1:0] XGPI;
    logic             cfg_we = 1'b0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [WIDTH-1:0] cfg_mask = '0;
    logic [WIDTH-1:0] cfg_match = '0;
    logic [WIDTH-1:0] cfg_resp = '0;
    logic             cfg_ne = 1'b0;
    logic [DLY_W-1:0] cfg_delay = '0;
    logic [AW:0]      num_steps = '0;
    logic [DLY_W-1:0] timeout_lim = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, timeout;
    logic [AW-1:0]    step;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb_q[$];

    gpio_response_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
        .XCLK(XCLK), .XRESET_N(XRESET_N), .XGPO(XGPO), .XGPI(XGPI),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
        .cfg_match(cfg_match), .cfg_resp(cfg_resp), .cfg_ne(cfg_ne),
        .cfg_delay(cfg_delay), .num_steps(num_steps), .timeout_lim(timeout_lim),
        .start(start), .abort(abort), .busy(busy), .done(done),
        .timeout(timeout), .step(step)
    );

    always #5 XCLK = ~XCLK;

    task automatic tick();
        @(posedge XCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic sb_pop_chk(input string tag);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            vectors++;
            assert (sb_q.size() != 0) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, XGPI);
            end
        end else begin
            e = sb_q.pop_front();
            chk(tag, XGPI, e);
        end
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [31:0] m,
                             input logic [31:0] mt, input logic ne,
                             input logic [31:0] r, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_mask  = m;
        cfg_match = mt;
        cfg_ne    = ne;
        cfg_resp  = r;
        cfg_delay = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        ticks(3);
        chk("rst_xgpi", XGPI, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_tmo", 32'(timeout), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        #3 XRESET_N = 1'b1;
        tick();

        // Single inverted-match entry, zero delay
        cfg_write(2'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h1234_5678, 16'd0);
        num_steps = 3'd1;
        timeout_lim = '0;
        XGPO = '0;
        do_start();
        chk("t1_busy", 32'(busy), 32'h1);
        ticks(2);
        chk("t1_idle_xgpi", XGPI, 32'h0);
        XGPO = 32'h0000_0001;
        sb_push(32'h1234_5678);
        tick();
        chk("t1_pre_xgpi", XGPI, 32'h0);
        tick();
        sb_pop_chk("t1_xgpi");
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_busy_end", 32'(busy), 32'h0);

        // Two entries with delay 3; num_steps change while busy is ignored
        cfg_write(2'd0, 32'hFF, 32'hAA, 1'b0, 32'h11, 16'd3);
        cfg_write(2'd1, 32'hFF, 32'hBB, 1'b0, 32'h22, 16'd3);
        XGPO = '0;
        num_steps = 3'd2;
        do_start();
        chk("t2_start_clr", XGPI, 32'h0);
        chk("t2_step0", 32'(step), 32'h0);
        num_steps = 3'd1;
        XGPO = 32'hAA;
        sb_push(32'h11);
        ticks(4);
        chk("t2_hold0", XGPI, 32'h0);
        tick();
        sb_pop_chk("t2_xgpi0");
        chk("t2_step1", 32'(step), 32'h1);
        chk("t2_busy_mid", 32'(busy), 32'h1);
        XGPO = 32'hBB;
        sb_push(32'h22);
        ticks(4);
        chk("t2_hold1", XGPI, 32'h11);
        tick();
        sb_pop_chk("t2_xgpi1");
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_step_end", 32'(step), 32'h1);

        // Timeout after 10 WAIT edges, then disabled timeout
        XGPO = '0;
        timeout_lim = 16'd10;
        num_steps = 3'd1;
        do_start();
        ticks(9);
        chk("t3_busy9", 32'(busy), 32'h1);
        chk("t3_tmo9", 32'(timeout), 32'h0);
        tick();
        chk("t3_tmo10", 32'(timeout), 32'h1);
        chk("t3_busy10", 32'(busy), 32'h0);
        chk("t3_xgpi", XGPI, 32'h0);
        timeout_lim = '0;
        do_start();
        ticks(1000);
        chk("t3_nolim_busy", 32'(busy), 32'h1);
        chk("t3_nolim_tmo", 32'(timeout), 32'h0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_busy", 32'(busy), 32'h0);

        // Abort during DELAY of the second step
        XGPO = '0;
        num_steps = 3'd2;
        do_start();
        XGPO = 32'hAA;
        sb_push(32'h11);
        ticks(5);
        sb_pop_chk("t4_xgpi0");
        XGPO = 32'hBB;
        ticks(2);
        chk("t4_in_delay", 32'(busy), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_xgpi", XGPI, 32'h0);
        chk("t4_abort_busy", 32'(busy), 32'h0);
        chk("t4_abort_step", 32'(step), 32'h0);
        ticks(4);
        chk("t4_noload", XGPI, 32'h0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t4_sa_busy", 32'(busy), 32'h0);
        chk("t4_sa_done", 32'(done), 32'h0);

        // Table write while busy is ignored; num_steps=0 finishes immediately
        XGPO = '0;
        num_steps = 3'd1;
        do_start();
        cfg_write(2'd0, 32'hFF, 32'hAA, 1'b0, 32'h99, 16'd0);
        XGPO = 32'hAA;
        sb_push(32'h11);
        ticks(4);
        chk("t5_hold", XGPI, 32'h0);
        tick();
        sb_pop_chk("t5_old_resp");
        chk("t5_done", 32'(done), 32'h1);
        num_steps = 3'd0;
        do_start();
        chk("t5_zero_done", 32'(done), 32'h1);
        chk("t5_zero_busy", 32'(busy), 32'h0);
        chk("t5_zero_xgpi", XGPI, 32'h0);

        // Asynchronous reset mid-WAIT
        XGPO = '0;
        num_steps = 3'd2;
        do_start();
        XGPO = 32'hAA;
        sb_push(32'h11);
        ticks(5);
        sb_pop_chk("t6_xgpi0");
        XGPO = '0;
        tick();
        #2 XRESET_N = 1'b0;
        #1;
        chk("t6_rst_xgpi", XGPI, 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_step", 32'(step), 32'h0);
        chk("t6_rst_done", 32'(done), 32'h0);
        tick();
        XRESET_N = 1'b1;
        num_steps = 3'd1;
        do_start();
        tick();
        chk("t6_cleared_done", 32'(done), 32'h1);
        chk("t6_cleared_busy", 32'(busy), 32'h0);
        cfg_write(2'd0, 32'hFF, 32'hAA, 1'b0, 32'h55, 16'd0);
        XGPO = 32'hAA;
        sb_push(32'h55);
        do_start();
        tick();
        sb_pop_chk("t6_rerun_xgpi");
        chk("t6_rerun_done", 32'(done), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
